cpu_mem_bridge: RTL and testbench

Memory bus bridge between the 8227 CPU core's external bus pins and a single-ported, variable-latency byte memory. Captures each CPU bus cycle, posts writes into a two-entry write buffer so the core never stalls on stores, and stalls reads by holding `ready` low until data returns. Sits directly downstream of the core's `AddressBusHigh/Low`, `dataBusOutput` and `readNotWrite` outputs, and upstream of its `dataBusInput` and `ready` inputs.

---
 rtl/cpu_mem_bridge.sv | 193 +++++++++++++++++++
 tb/tb_cpu_mem_bridge.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_bridge.sv
// cpu_mem_bridge: 8227 CPU bus to single-ported variable-latency byte memory, 2-entry posted write buffer.
// Optional request timeout is built when CPU_MEM_BRIDGE_TIMEOUT_EN is defined; otherwise bus_err is tied 0.
module cpu_mem_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [7:0]  TIMEOUT_RDATA  = 8'hFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_valid,
   input  logic [15:0] cpu_addr,
   input  logic        cpu_rnw,
   input  logic [7:0]  cpu_wdata,
   output logic [7:0]  cpu_rdata,
   output logic        ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic        mem_ack,
   input  logic [7:0]  mem_rdata,
   output logic        wr_overflow,
   output logic        bus_err
);

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

   state_t      r_state;
   logic [15:0] r_fifo_addr [2];
   logic [7:0]  r_fifo_data [2];
   logic        r_wr_ptr;
   logic        r_rd_ptr;
   logic [1:0]  r_count;
   logic        r_rd_pend;
   logic [15:0] r_rd_addr;
   logic [7:0]  r_cpu_rdata;
   logic        r_mem_req;
   logic        r_mem_we;
   logic [15:0] r_mem_addr;
   logic [7:0]  r_mem_wdata;
   logic        r_wr_overflow;

   logic w_wr_strobe;
   logic w_rd_strobe;
   logic w_full;
   logic w_empty;
   logic w_done;
   logic w_abort;
   logic w_pop;
   logic w_push;

   assign w_wr_strobe = cpu_valid & ~cpu_rnw;
   assign w_rd_strobe = cpu_valid & cpu_rnw;
   assign w_full      = (r_count == 2'd2);
   assign w_empty     = (r_count == 2'd0);
   assign w_done      = r_mem_req & mem_ack;
   assign w_pop       = (r_state == S_WRITE) & (w_done | w_abort);
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   assign w_push      = w_wr_strobe & (~w_full | w_pop);

`ifdef CPU_MEM_BRIDGE_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] r_tmo_cnt;
   logic       r_bus_err;

   // Abort on the TIMEOUT_CYCLES-th unacknowledged request cycle; a same-cycle ack wins.
   assign w_abort = r_mem_req & ~mem_ack & (r_tmo_cnt == TMO_LAST);
   assign bus_err = r_bus_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tmo_cnt <= '0;
         r_bus_err <= 1'b0;
      end else begin
         if (!r_mem_req)
            r_tmo_cnt <= '0;
         else if (!mem_ack)
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
         if (w_abort)
            r_bus_err <= 1'b1;
      end
   end
`else
   assign w_abort = 1'b0;
   assign bus_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_addr[r_wr_ptr] <= cpu_addr;
         r_fifo_data[r_wr_ptr] <= cpu_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr      <= 1'b0;
         r_rd_ptr      <= 1'b0;
         r_count       <= '0;
         r_wr_overflow <= 1'b0;
      end else begin
         if (w_push)
            r_wr_ptr <= ~r_wr_ptr;
         if (w_pop)
            r_rd_ptr <= ~r_rd_ptr;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
         if (w_wr_strobe & ~w_push)
            r_wr_overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_rd_pend   <= 1'b0;
         r_rd_addr   <= '0;
         r_cpu_rdata <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         if (w_rd_strobe & ~r_rd_pend) begin
            r_rd_pend <= 1'b1;
            r_rd_addr <= cpu_addr;
         end
         case (r_state)
            S_IDLE: begin
               // With the FIFO empty, a strobe in this cycle is launched directly from the bus.
               if (r_rd_pend & w_empty) begin
                  r_state    <= S_READ;
                  r_mem_req  <= 1'b1;
                  r_mem_we   <= 1'b0;
                  r_mem_addr <= r_rd_addr;
               end else if (!w_empty) begin
                  r_state     <= S_WRITE;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= 1'b1;
                  r_mem_addr  <= r_fifo_addr[r_rd_ptr];
                  r_mem_wdata <= r_fifo_data[r_rd_ptr];
               end else if (w_wr_strobe) begin
                  r_state     <= S_WRITE;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= 1'b1;
                  r_mem_addr  <= cpu_addr;
                  r_mem_wdata <= cpu_wdata;
               end else if (w_rd_strobe) begin
                  r_state    <= S_READ;
                  r_mem_req  <= 1'b1;
                  r_mem_we   <= 1'b0;
                  r_mem_addr <= cpu_addr;
               end
            end
            S_WRITE: begin
               if (w_done | w_abort) begin
                  r_state   <= S_IDLE;
                  r_mem_req <= 1'b0;
               end
            end
            S_READ: begin
               if (w_done) begin
                  r_state     <= S_IDLE;
                  r_mem_req   <= 1'b0;
                  r_cpu_rdata <= mem_rdata;
                  r_rd_pend   <= 1'b0;
               end else if (w_abort) begin
                  r_state     <= S_IDLE;
                  r_mem_req   <= 1'b0;
                  r_cpu_rdata <= TIMEOUT_RDATA;
                  r_rd_pend   <= 1'b0;
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_mem_req <= 1'b0;
            end
         endcase
      end
   end

   assign ready       = ~r_rd_pend & ~w_rd_strobe;
   assign cpu_rdata   = r_cpu_rdata;
   assign mem_req     = r_mem_req;
   assign mem_we      = r_mem_we;
   assign mem_addr    = r_mem_addr;
   assign mem_wdata   = r_mem_wdata;
   assign wr_overflow = r_wr_overflow;

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// tb_cpu_mem_bridge: randomized CPU/memory traffic against a transaction-queue model of the bridge.
// Timeout checks are included when CPU_MEM_BRIDGE_TIMEOUT_EN is defined.
module tb_cpu_mem_bridge;
   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_valid;
   logic [15:0] cpu_addr;
   logic        cpu_rnw;
   logic [7:0]  cpu_wdata;
   logic [7:0]  cpu_rdata;
   logic        ready;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_ack;
   logic [7:0]  mem_rdata;
   logic        wr_overflow;
   logic        bus_err;

   always #5 clk = ~clk;

   cpu_mem_bridge #(.TIMEOUT_CYCLES(TMO), .TIMEOUT_RDATA(8'hFF)) dut (
      .clk(clk), .rst(rst), .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_rnw(cpu_rnw),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .ready(ready), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .wr_overflow(wr_overflow), .bus_err(bus_err)
   );

   typedef struct packed {logic we; logic [15:0] addr; logic [7:0] data;} txn_t;

   // Model: queue of accepted bus cycles in service order, plus sticky flags.
   txn_t        q[$];
   logic [23:0] wlog[$];
   logic [7:0]  mem [0:65535];
   bit          m_rd_pend, m_req, m_ovf, m_berr;
   logic [7:0]  m_rdata;
   int          m_wcount, m_tmo;
   int          n_vec, n_err;
   int          lat, force_lat;
   bit          in_req, hold;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_rd_pend = 0; m_req = 0; m_ovf = 0; m_berr = 0;
      m_rdata = 8'h00; m_wcount = 0; m_tmo = 0;
   endtask

   task automatic cycle(input bit r, input bit v, input bit rnw, input logic [15:0] a, input logic [7:0] d);
      txn_t h;
      bit done, abort, pop;
      @(negedge clk);
      rst = r; cpu_valid = v; cpu_rnw = rnw; cpu_addr = a; cpu_wdata = d;
      if (mem_req) begin
         if (!in_req) begin
            in_req = 1;
            lat = (force_lat >= 0) ? force_lat : $urandom_range(0, 5);
         end
         mem_ack = !hold && (lat == 0);
         if (lat > 0) lat--;
      end else begin
         in_req = 0;
         mem_ack = 0;
      end
      mem_rdata = (mem_ack && !mem_we) ? mem[mem_addr] : 8'($urandom);
      if (mem_ack && mem_we) wlog.push_back({mem_addr, mem_wdata});
      #1;
      chk("ready", ready, !m_rd_pend && !(v && rnw));
      chk("cpu_rdata", cpu_rdata, m_rdata);
      chk("wr_overflow", wr_overflow, m_ovf);
      chk("bus_err", bus_err, m_berr);
      chk("mem_req", mem_req, m_req);
      if (m_req && q.size() > 0) begin
         h = q[0];
         chk("mem_we", mem_we, h.we);
         chk("mem_addr", mem_addr, h.addr);
         if (h.we) chk("mem_wdata", mem_wdata, h.data);
      end
      if (r) begin
         model_reset();
         return;
      end
      done = m_req && mem_ack;
      abort = 0;
`ifdef CPU_MEM_BRIDGE_TIMEOUT_EN
      if (m_req && !mem_ack) begin
         if (m_tmo == TMO - 1) abort = 1;
         else m_tmo++;
      end
`endif
      pop = 0;
      if ((done || abort) && q.size() > 0) begin
         h = q.pop_front();
         if (h.we) begin
            if (done) mem[h.addr] = h.data;
            m_wcount--;
            pop = 1;
         end else begin
            m_rdata = done ? mem[h.addr] : 8'hFF;
            m_rd_pend = 0;
         end
         if (abort) m_berr = 1;
      end
      if (v && !rnw) begin
         if (m_wcount < 2 || pop) begin
            q.push_back({1'b1, a, d});
            m_wcount++;
         end else m_ovf = 1;
      end else if (v && rnw && !m_rd_pend) begin
         q.push_back({1'b0, a, 8'h00});
         m_rd_pend = 1;
      end
      if (m_req) m_req = !(done || abort);
      else m_req = (q.size() > 0);
      if (!m_req) m_tmo = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 16'h0000, 8'h00);
   endtask

   task automatic wait_ready(output int low);
      low = ready ? 0 : 1;
      for (int i = 0; i < 60 && !ready; i++) begin
         cycle(0, 0, 0, 16'h0000, 8'h00);
         if (!ready) low++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int low;
      logic [3:0] lo;
      int sel;
      n_vec = 0; n_err = 0; hold = 0; force_lat = -1; in_req = 0; lat = 0;
      rst = 1; cpu_valid = 0; cpu_rnw = 0; cpu_addr = '0; cpu_wdata = '0;
      mem_ack = 0; mem_rdata = '0;
      for (int i = 0; i < 65536; i++) mem[i] = 8'(i ^ (i >> 8));
      model_reset();
      cycle(1, 0, 0, 16'h0000, 8'h00);
      cycle(0, 0, 0, 16'h0000, 8'h00);
      chk("rst_rdata", cpu_rdata, 8'h00);
      chk("rst_ready", ready, 1'b1);
      chk("rst_req", mem_req, 1'b0);
      chk("rst_we", mem_we, 1'b0);
      chk("rst_addr", mem_addr, 16'h0000);
      chk("rst_wdata", mem_wdata, 8'h00);
      chk("rst_ovf", wr_overflow, 1'b0);
      chk("rst_berr", bus_err, 1'b0);

      // Read with L=3: ready low for 5 cycles from the strobe.
      mem[16'h1234] = 8'h5A;
      force_lat = 3;
      cycle(0, 1, 1, 16'h1234, 8'h00);
      wait_ready(low);
      chk("rd_low_cycles", low, 5);
      chk("rd_data", cpu_rdata, 8'h5A);

      // Two posted writes then a read of the second address.
      force_lat = -1;
      idle(2);
      wlog.delete();
      cycle(0, 1, 0, 16'h0200, 8'h11);
      cycle(0, 1, 0, 16'h0201, 8'h22);
      cycle(0, 1, 1, 16'h0201, 8'h00);
      wait_ready(low);
      chk("rd_after_wr", cpu_rdata, 8'h22);
      chk("wlog_count", wlog.size(), 2);
      if (wlog.size() == 2) begin
         chk("wlog0", wlog[0], 24'h020011);
         chk("wlog1", wlog[1], 24'h020122);
      end

      // Three writes, memory stalled: third is dropped.
      idle(3);
      hold = 1;
      cycle(0, 1, 0, 16'h0210, 8'hA1);
      cycle(0, 1, 0, 16'h0211, 8'hA2);
      cycle(0, 1, 0, 16'h0212, 8'hA3);
      idle(1);
`ifndef CPU_MEM_BRIDGE_TIMEOUT_EN
      chk("ovf_set", wr_overflow, 1'b1);
`endif
      hold = 0;
      idle(30);
      cycle(1, 0, 0, 16'h0000, 8'h00);
      // Ack lands in the third strobe's cycle: push+pop on a full FIFO.
      force_lat = 1;
      cycle(0, 1, 0, 16'h0220, 8'hB1);
      cycle(0, 1, 0, 16'h0221, 8'hB2);
      cycle(0, 1, 0, 16'h0222, 8'hB3);
      idle(1);
      chk("ovf_clear", wr_overflow, 1'b0);
      idle(20);

      // Reset while a read request is outstanding.
      hold = 1;
      cycle(0, 1, 1, 16'h0230, 8'h00);
      idle(2);
      chk("mid_req", mem_req, 1'b1);
      cycle(1, 0, 0, 16'h0000, 8'h00);
      hold = 0;
      cycle(0, 0, 0, 16'h0000, 8'h00);
      chk("post_rst_req", mem_req, 1'b0);
      chk("post_rst_ready", ready, 1'b1);
      chk("post_rst_rdata", cpu_rdata, 8'h00);

`ifdef CPU_MEM_BRIDGE_TIMEOUT_EN
      hold = 1;
      cycle(0, 1, 1, 16'h0300, 8'h00);
      wait_ready(low);
      chk("tmo_rdata", cpu_rdata, 8'hFF);
      chk("tmo_berr", bus_err, 1'b1);
      chk("tmo_ready", ready, 1'b1);
      hold = 0;
      cycle(1, 0, 0, 16'h0000, 8'h00);
      mem[16'h0300] = 8'hA5;
      force_lat = TMO - 1;
      cycle(0, 1, 1, 16'h0300, 8'h00);
      wait_ready(low);
      chk("tmo_race_rdata", cpu_rdata, 8'hA5);
      chk("tmo_race_berr", bus_err, 1'b0);
      cycle(1, 0, 0, 16'h0000, 8'h00);
`endif

      // Randomized legal CPU traffic with random memory latency.
      force_lat = -1;
      for (int i = 0; i < 2000; i++) begin
         sel = $urandom_range(0, 2);
         lo = 4'($urandom);
         if (!m_rd_pend && sel == 0)
            cycle(0, 1, $urandom_range(0, 1) == 1, {8'h02, 4'h0, lo}, 8'($urandom));
         else
            cycle(0, 0, 0, 16'h0000, 8'h00);
      end
      idle(20);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
